des_feistel_round_ctrl: RTL and testbench
=========================================

// Module: des_feistel_round_ctrl
// PURPOSE
//  Iterative DES Feistel round controller; sits directly downstream of des_pbox_permutations.
//  Holds the L/R halves of one block; each round it consumes the P-box output f(R,K) and computes
//  newL=R, newR=L^f. After 16 rounds it emits the pre-output block R16||L16 for the final permutation.
//  The external f-path (E-expansion, key XOR, S-boxes, P-box) is driven from r_out and round_idx.
// PARAMETERS
//  NUM_ROUNDS  16  number of Feistel rounds per block (DES fixed at 16; smaller values are for test only)
//  CNT_W       4   width of round counter; must satisfy 2**CNT_W >= NUM_ROUNDS
// PORTS
//  clk         in   1      rising-edge clock, single clock domain
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      load block_in and begin rounds; honoured only when busy=0
//  block_in    in   [0:63] post-IP block; [0:31]=L0, [32:63]=R0
//  f_valid     in   1      f_in carries f(R,K) for the current round
//  f_in        in   [0:31] P-box permuted output for the current round
//  r_out       out  [0:31] current R half; feeds the E-expansion of the f-path
//  round_idx   out  CNT_W  current round number 0..NUM_ROUNDS-1; selects the subkey
//  busy        out  1      high in RUN and DONE
//  done        out  1      one-cycle pulse; block_out valid on this cycle and held until the next start
//  block_out   out  [0:63] pre-output R16||L16, i.e. [0:31]=R, [32:63]=L; no final swap
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; L,R,round_idx,block_out=0; busy=0; done=0.
//  States: IDLE -> RUN -> DONE -> IDLE. All outputs are registered.
//  IDLE: start=1 -> L<=block_in[0:31], R<=block_in[32:63], round_idx<=0, go to RUN. f_valid is ignored.
//  RUN: f_valid=1 -> L<=R, R<=L^f_in, round_idx<=round_idx+1.
//    If round_idx==NUM_ROUNDS-1 at acceptance -> block_out<={R^L... new R, new L}, i.e. {L^f_in, R},
//    round_idx<=0, go to DONE.
//    f_valid=0 -> hold all state. No timeout; the f-path may stall for any number of cycles.
//  DONE: done=1 for exactly this cycle, then IDLE unconditionally. f_valid is ignored.
//  start while busy=1 is ignored; there is no abort. Only rst aborts a block.
//  start in the DONE cycle is ignored; the earliest new start is accepted the cycle after done.
//  Throughput: 1 round per accepted f_valid. Minimum latency from start to done is NUM_ROUNDS+2 cycles
//    with f_valid held high: 1 load cycle, 16 round cycles, 1 DONE cycle.
//  r_out=R and round_idx change only on the clock edge that accepts a round, so f_in must reflect the
//    current r_out/round_idx when f_valid is asserted.
//  block_out updates only on the final-round edge and is stable otherwise, including in IDLE.
//  Reset mid-block clears everything; no partial result appears on block_out and done does not pulse.
// TESTING
//  1 Reset: assert rst mid-RUN (round 7) -> next cycle busy=0, done=0, block_out=0, round_idx=0; state is IDLE.
//  2 Zero f: block_in=CC00CCFF_F0AAF0AA, f_in=0 for all 16 rounds
//    -> done one cycle after the 16th f_valid, block_out=F0AAF0AA_CC00CCFF.
//  3 Single-round f: same block_in, f_in=12345678 in round 0 and 0 in rounds 1-15 -> block_out=F0AAF0AA_DE349A87.
//  4 Stalls: test 3 with random f_valid gaps of 0-5 cycles -> identical block_out;
//    round_idx steps 0..15 once per accepted f_valid; r_out held during gaps.
//  5 Protocol: start pulsed during RUN and on the done cycle -> ignored, result unchanged;
//    f_valid asserted in IDLE -> no state change.
//  6 Back-to-back: second start the cycle after done -> accepted; block_out keeps the first result
//    until its own done; full FIPS-46 vector (key 133457799BBCDFF1, with real f-path) gives pre-FP 0A4CD995_43423234.

Source files
------------

// File: rtl/des_feistel_round_ctrl.sv
// Iterative DES Feistel round controller.
// Holds the L/R halves of one block and applies one round per accepted f(R,K)
// from the external f-path: newL = R, newR = L ^ f. After NUM_ROUNDS rounds it
// presents the pre-output block R||L (no final swap) for the final permutation.
//
// Bit numbering: DES bit 1 (the leftmost, most significant bit) maps to the MSB
// of each vector, so block_in[63:32] is L0 and block_in[31:0] is R0. The same
// holds for block_out ([63:32] = R16, [31:0] = L16), f_in and r_out.
module des_feistel_round_ctrl #(
    parameter int NUM_ROUNDS = 16,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [63:0]      block_in,
    input  logic             f_valid,
    input  logic [31:0]      f_in,
    output logic [31:0]      r_out,
    output logic [CNT_W-1:0] round_idx,
    output logic             busy,
    output logic             done,
    output logic [63:0]      block_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS - 1);

    state_e           state_q;
    logic [31:0]      l_q;
    logic [31:0]      r_q;
    logic [CNT_W-1:0] round_q;
    logic             busy_q;
    logic             done_q;
    logic [63:0]      block_out_q;

    // Next-state values for the round datapath, used only when a round is accepted.
    logic [31:0]      r_d;
    logic [CNT_W-1:0] round_d;

    // Feistel mix and round counter increment for the round being accepted.
    always_comb begin
        r_d     = l_q ^ f_in;
        round_d = round_q + CNT_W'(1);
    end

    // Controller FSM: load, iterate rounds on f_valid, pulse done, return to idle.
    // Every output is a register updated here so downstream timing starts at a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            l_q         <= '0;
            r_q         <= '0;
            round_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            block_out_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every update here see the
            // pre-edge values, so the L<=R / R<=L^f swap needs no temporary.
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // f_valid is meaningless without a loaded block.
                    if (start) begin
                        l_q     <= block_in[63:32];
                        r_q     <= block_in[31:0];
                        round_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // start is ignored here; only rst can abort a block.
                    if (f_valid) begin
                        l_q <= r_q;
                        r_q <= r_d;
                        if (round_q == LAST_ROUND) begin
                            // Pre-output is R16||L16 with no final swap.
                            block_out_q <= {r_d, r_q};
                            round_q     <= '0;
                            done_q      <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            round_q <= round_d;
                        end
                    end
                end
                ST_DONE: begin
                    // start arriving alongside done is dropped; the next block
                    // can begin one cycle later.
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign r_out     = r_q;
    assign round_idx = round_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign block_out = block_out_q;

endmodule

// File: tb/tb_des_feistel_round_ctrl.sv
// Testbench for des_feistel_round_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge. A block-level
// Feistel model and a full DES f-function/key-schedule model provide expectations.
module tb_des_feistel_round_ctrl;

    localparam int NR = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [63:0]   block_in;
    logic          f_valid;
    logic [31:0]   f_in;
    logic [31:0]   r_out;
    logic [CW-1:0] round_idx;
    logic          busy;
    logic          done;
    logic [63:0]   block_out;

    int checks = 0;
    int errors = 0;

    // Model state: halves of the block in flight and the last published result.
    logic [31:0] m_l, m_r;
    logic [63:0] m_out;

    logic [47:0] ks [16];
    logic [31:0] fvec [16];

    always #5 clk = ~clk;

    des_feistel_round_ctrl #(.NUM_ROUNDS(NR), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .block_in  (block_in),
        .f_valid   (f_valid),
        .f_in      (f_in),
        .r_out     (r_out),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done),
        .block_out (block_out)
    );

    // ---------------- DES reference tables (1-based DES bit numbers) ----------------
    int PC1 [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                     63,55,47,39,31,23,15, 7,62,54,46,38,30,22,14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
    int PC2 [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int PERM [32] = '{16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
                      2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
    int SBOX [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

    // Round subkey K(rnd+1) from a 64-bit key. DES bit n of a W-bit vector is [W-n].
    function automatic logic [47:0] subkey(input logic [63:0] key, input int rnd);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] k;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r <= rnd; r++)
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2[i]];
        return k;
    endfunction

    // DES f(R,K): E-expansion, key mix, S-boxes, P-box.
    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s, p;
        int row, col, v, e_idx;
        for (int j = 0; j < 8; j++)
            for (int b = 0; b < 6; b++) begin
                e_idx = (4*j - 1 + b + 32) % 32;
                x[47-(6*j+b)] = r[31-e_idx];
            end
        x = x ^ k;
        for (int j = 0; j < 8; j++) begin
            row = 2*int'(x[47-6*j]) + int'(x[42-6*j]);
            col = 8*int'(x[46-6*j]) + 4*int'(x[45-6*j]) + 2*int'(x[44-6*j]) + int'(x[43-6*j]);
            v = SBOX[j*64 + row*16 + col];
            for (int b = 0; b < 4; b++) s[31-(4*j+b)] = v[3-b];
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-PERM[i]];
        return p;
    endfunction

    // Whole-block Feistel result for a given list of per-round f values.
    function automatic logic [63:0] feistel_ref(input logic [63:0] blk, input logic [31:0] fv [16]);
        logic [31:0] l, r, t;
        l = blk[63:32];
        r = blk[31:0];
        for (int i = 0; i < NR; i++) begin
            t = l ^ fv[i];
            l = r;
            r = t;
        end
        return {r, l};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Outputs during a block in flight, before round r is accepted.
    task automatic check_running(input int r);
        check("r_out", 64'(r_out), 64'(m_r));
        check("round_idx", 64'(round_idx), 64'(r));
        check("busy_run", 64'(busy), 64'd1);
        check("done_run", 64'(done), 64'd0);
        check("block_out_held", block_out, m_out);
    endtask

    // Runs one block from the current falling edge. Optional random stalls up to
    // max_gap cycles per round; poke pulses start mid-run and on the done cycle.
    // With use_des the f values come from the DES model and subkeys ks[].
    task automatic run_block(input logic [63:0] blk, input logic [31:0] fv [16], input bit use_des,
                             input int max_gap, input bit poke, input logic [63:0] exp);
        logic [31:0] f, t;
        int gap;
        start    = 1'b1;
        block_in = blk;
        @(negedge clk);
        start    = 1'b0;
        block_in = 64'(~blk);
        m_l = blk[63:32];
        m_r = blk[31:0];
        for (int r = 0; r < NR; r++) begin
            check_running(r);
            if (poke && r == 5) begin
                start   = 1'b1;
                f_valid = 1'b0;
                @(negedge clk);
                start = 1'b0;
                check_running(r);
            end
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                f_valid = 1'b0;
                f_in    = $urandom;
                @(negedge clk);
                check_running(r);
            end
            f = use_des ? des_f(m_r, ks[r]) : fv[r];
            f_valid = 1'b1;
            f_in    = f;
            @(negedge clk);
            f_valid = 1'b0;
            f_in    = $urandom;
            t   = m_l ^ f;
            m_l = m_r;
            m_r = t;
        end
        check("done_pulse", 64'(done), 64'd1);
        check("busy_done", 64'(busy), 64'd1);
        check("block_out_result", block_out, exp);
        if (poke) begin
            start    = 1'b1;
            block_in = 64'(~blk);
        end
        @(negedge clk);
        start = 1'b0;
        m_out = exp;
        check("done_cleared", 64'(done), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        check("block_out_stable", block_out, m_out);
        check("r_out_idle", 64'(r_out), 64'(m_r));
    endtask

    typedef struct {
        logic [63:0] blk;
        logic [31:0] f0;
        int          gap;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [63:0] blk, exp;

        vecs[0] = '{64'hCC00CCFF_F0AAF0AA, 32'h0000_0000, 0, 64'hF0AAF0AA_CC00CCFF};
        vecs[1] = '{64'hCC00CCFF_F0AAF0AA, 32'h1234_5678, 0, 64'hF0AAF0AA_DE349A87};
        vecs[2] = '{64'hCC00CCFF_F0AAF0AA, 32'h1234_5678, 5, 64'hF0AAF0AA_DE349A87};
        vecs[3] = '{64'h01234567_89ABCDEF, 32'hFFFF_FFFF, 2, 64'h89ABCDEF_FEDCBA98};

        for (int i = 0; i < NR; i++) ks[i] = subkey(64'h13345779_9BBCDFF1, i);

        rst      = 1'b1;
        start    = 1'b0;
        block_in = '0;
        f_valid  = 1'b0;
        f_in     = '0;
        m_l = '0;
        m_r = '0;
        m_out = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_block_out", block_out, 64'd0);
        check("reset_round_idx", 64'(round_idx), 64'd0);
        check("reset_r_out", 64'(r_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, issued back to back (each start the cycle after done).
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < NR; i++) fvec[i] = '0;
            fvec[0] = vecs[v].f0;
            run_block(vecs[v].blk, fvec, 1'b0, vecs[v].gap, 1'b0, vecs[v].exp);
        end

        // Random blocks and f values with random stalls; every other one pokes start.
        for (int n = 0; n < 6; n++) begin
            blk = {$urandom, $urandom};
            for (int i = 0; i < NR; i++) fvec[i] = $urandom;
            exp = feistel_ref(blk, fvec);
            run_block(blk, fvec, 1'b0, 3, n[0], exp);
        end

        // f_valid in IDLE must not disturb anything.
        for (int i = 0; i < 3; i++) begin
            f_valid = 1'b1;
            f_in    = $urandom;
            @(negedge clk);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_done", 64'(done), 64'd0);
            check("idle_r_out", 64'(r_out), 64'(m_r));
            check("idle_round_idx", 64'(round_idx), 64'd0);
            check("idle_block_out", block_out, m_out);
        end
        f_valid = 1'b0;

        // Reset in the middle of a block, after 7 rounds have been accepted.
        start    = 1'b1;
        block_in = 64'hCC00CCFF_F0AAF0AA;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < 7; r++) begin
            f_valid = 1'b1;
            f_in    = $urandom;
            @(negedge clk);
        end
        f_valid = 1'b0;
        check("pre_reset_round_idx", 64'(round_idx), 64'd7);
        rst = 1'b1;
        #1;
        check("midrun_reset_busy", 64'(busy), 64'd0);
        check("midrun_reset_done", 64'(done), 64'd0);
        check("midrun_reset_block_out", block_out, 64'd0);
        check("midrun_reset_round_idx", 64'(round_idx), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        m_l = '0;
        m_r = '0;
        m_out = '0;
        for (int i = 0; i < 3; i++) begin
            f_valid = 1'b1;
            f_in    = $urandom;
            @(negedge clk);
            check("post_reset_done", 64'(done), 64'd0);
            check("post_reset_busy", 64'(busy), 64'd0);
            check("post_reset_block_out", block_out, 64'd0);
        end
        f_valid = 1'b0;

        // Zero-f block followed back to back by the FIPS-46 example with a real f-path.
        for (int i = 0; i < NR; i++) fvec[i] = '0;
        run_block(64'hCC00CCFF_F0AAF0AA, fvec, 1'b0, 0, 1'b0, 64'hF0AAF0AA_CC00CCFF);
        run_block(64'hCC00CCFF_F0AAF0AA, fvec, 1'b1, 2, 1'b1, 64'h0A4CD995_43423234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
